// File: rtl/unsigned_calc_pkg.sv
// Shared constants for the 7a-3b+6c calculator and its solver.
// Operand/result widths, coefficients, walk deltas, FSM codes.
package unsigned_calc_pkg;

    localparam int W_OP  = 4;
    localparam int W_RES = 9;

    localparam int K_A = 7;
    localparam int K_B = 3;
    localparam int K_C = 6;

    // Accumulator deltas (mod 512) for each odometer step
    localparam logic [W_RES-1:0] D_C = 9'd6;
    localparam logic [W_RES-1:0] D_B = 9'd419;
    localparam logic [W_RES-1:0] D_A = 9'd474;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SEARCH = 1'b1;

endpackage

// File: rtl/unsigned_calc_step_v.sv
// Candidate walker: advances {a,b,c} by one and keeps
// acc = 7a-3b+6c (mod 512) without multipliers.
module unsigned_calc_step_v
    import unsigned_calc_pkg::*;
(
    input  logic [W_OP-1:0]  a_i,
    input  logic [W_OP-1:0]  b_i,
    input  logic [W_OP-1:0]  c_i,
    input  logic [W_RES-1:0] acc_i,
    output logic [W_OP-1:0]  a_o,
    output logic [W_OP-1:0]  b_o,
    output logic [W_OP-1:0]  c_o,
    output logic [W_RES-1:0] acc_o,
    output logic             last_o
);

    // Odometer increment with c least significant
    always_comb begin
        a_o    = a_i;
        b_o    = b_i;
        c_o    = c_i;
        acc_o  = acc_i;
        last_o = &{a_i, b_i, c_i};
        if (c_i != '1) begin
            c_o   = c_i + 1'b1;
            acc_o = acc_i + D_C;
        end else if (b_i != '1) begin
            c_o   = '0;
            b_o   = b_i + 1'b1;
            acc_o = acc_i + D_B;
        end else begin
            c_o   = '0;
            b_o   = '0;
            a_o   = a_i + 1'b1;
            acc_o = acc_i + D_A;
        end
    end

endmodule

// File: rtl/unsigned_calc_solver_v.sv
// Inverse of the 7a-3b+6c calculator: walks all 4096 operand
// triples in order and returns the first one hitting the target.
module unsigned_calc_solver_v
    import unsigned_calc_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [W_RES-1:0] i_fu,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_found,
    output logic [W_OP-1:0]  o_au,
    output logic [W_OP-1:0]  o_bu,
    output logic [W_OP-1:0]  o_cu
);

    logic [0:0]       state_q, state_d;
    logic [W_RES-1:0] tgt_q, tgt_d;
    logic [W_RES-1:0] acc_q, acc_d;
    logic [W_OP-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic [W_OP-1:0]  au_q, au_d, bu_q, bu_d, cu_q, cu_d;

    logic [W_OP-1:0]  a_nx, b_nx, c_nx;
    logic [W_RES-1:0] acc_nx;
    logic             last;

    unsigned_calc_step_v u_step (
        .a_i    (a_q),
        .b_i    (b_q),
        .c_i    (c_q),
        .acc_i  (acc_q),
        .a_o    (a_nx),
        .b_o    (b_nx),
        .c_o    (c_nx),
        .acc_o  (acc_nx),
        .last_o (last)
    );

    // Next-state: accept, test one candidate per cycle, finish
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        found_d = found_q;
        au_d    = au_q;
        bu_d    = bu_q;
        cu_d    = cu_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_SEARCH;
                    tgt_d   = i_fu;
                    acc_d   = '0;
                    a_d     = '0;
                    b_d     = '0;
                    c_d     = '0;
                    busy_d  = 1'b1;
                    found_d = 1'b0;
                    au_d    = '0;
                    bu_d    = '0;
                    cu_d    = '0;
                end
            end
            ST_SEARCH: begin
                if (acc_q == tgt_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    found_d = 1'b1;
                    au_d    = a_q;
                    bu_d    = b_q;
                    cu_d    = c_q;
                end else if (last) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    found_d = 1'b0;
                    au_d    = '0;
                    bu_d    = '0;
                    cu_d    = '0;
                end else begin
                    a_d   = a_nx;
                    b_d   = b_nx;
                    c_d   = c_nx;
                    acc_d = acc_nx;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            tgt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            au_q    <= '0;
            bu_q    <= '0;
            cu_q    <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            found_q <= found_d;
            au_q    <= au_d;
            bu_q    <= bu_d;
            cu_q    <= cu_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_found = found_q;
    assign o_au    = au_q;
    assign o_bu    = bu_q;
    assign o_cu    = cu_q;

endmodule

// File: tb/tb_unsigned_calc_solver_v.sv
// Directed bench for unsigned_calc_solver_v.
// Checks latency, results, ignore rules and mid-search reset.
module tb_unsigned_calc_solver_v;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic [8:0] i_fu = '0;
    logic       o_busy, o_done, o_found;
    logic [3:0] o_au, o_bu, o_cu;

    int n_cmp = 0;
    int n_bad = 0;

    unsigned_calc_solver_v dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_fu    (i_fu),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_found (o_found),
        .o_au    (o_au),
        .o_bu    (o_bu),
        .o_cu    (o_cu)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [8:0] calc(input int a, input int b, input int c);
        int v;
        v = 7 * a - 3 * b + 6 * c;
        return v[8:0];
    endfunction

    // Drive a one-cycle start; returns #1 after the accept edge
    task automatic start(input logic [8:0] fu);
        @(negedge i_clk);
        i_start = 1'b1;
        i_fu    = fu;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    // Count cycles until o_done; -1 if the bound expires
    task automatic wait_done(input int lim, output int cyc);
        cyc = -1;
        for (int k = 1; k <= lim; k++) begin
            @(posedge i_clk);
            #1;
            if (o_done) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        n_cmp++;
        if ({o_busy, o_done, o_found, o_au, o_bu, o_cu} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset: got %b want 0",
                     {o_busy, o_done, o_found, o_au, o_bu, o_cu});
        end
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_match_vectors();
        logic [8:0] fu_t [3] = '{9'd0, 9'd6, 9'd467};
        int         lat_t[3] = '{1, 2, 241};
        logic [11:0] abc_t[3] = '{12'h000, 12'h001, 12'h0F0};
        int cyc;
        for (int i = 0; i < 3; i++) begin
            start(fu_t[i]);
            n_cmp++;
            if (o_busy !== 1'b1 || o_found !== 1'b0) begin
                n_bad++;
                $display("FAIL accept[%0d]: busy=%b found=%b want 1,0",
                         i, o_busy, o_found);
            end
            wait_done(5000, cyc);
            n_cmp++;
            if (cyc !== lat_t[i]) begin
                n_bad++;
                $display("FAIL latency fu=%0d: got %0d want %0d",
                         fu_t[i], cyc, lat_t[i]);
            end
            n_cmp++;
            if ({o_found, o_au, o_bu, o_cu} !== {1'b1, abc_t[i]}
                || o_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL result fu=%0d: got f=%b %h busy=%b want 1 %h",
                         fu_t[i], o_found, {o_au, o_bu, o_cu}, o_busy,
                         abc_t[i]);
            end
            n_cmp++;
            if (calc(o_au, o_bu, o_cu) !== fu_t[i]) begin
                n_bad++;
                $display("FAIL xcheck fu=%0d: model gives %0d",
                         fu_t[i], calc(o_au, o_bu, o_cu));
            end
            @(posedge i_clk);
            #1;
            n_cmp++;
            if (o_done !== 1'b0 || o_found !== 1'b1) begin
                n_bad++;
                $display("FAIL hold fu=%0d: done=%b found=%b want 0,1",
                         fu_t[i], o_done, o_found);
            end
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        start(9'd195);
        cyc = -1;
        for (int k = 1; k <= 5000; k++) begin
            if (k == 50) begin
                i_start = 1'b1;
                i_fu    = 9'd0;
            end else if (k == 51) begin
                i_start = 1'b0;
                i_fu    = 9'd6;
            end
            @(posedge i_clk);
            #1;
            if (o_done) begin
                cyc = k;
                break;
            end
        end
        n_cmp++;
        if (cyc !== 3856) begin
            n_bad++;
            $display("FAIL latency fu=195: got %0d want 3856", cyc);
        end
        n_cmp++;
        if ({o_found, o_au, o_bu, o_cu} !== {1'b1, 12'hF0F}) begin
            n_bad++;
            $display("FAIL result fu=195: got f=%b %h want 1 f0f",
                     o_found, {o_au, o_bu, o_cu});
        end
        n_cmp++;
        if (calc(o_au, o_bu, o_cu) !== 9'd195) begin
            n_bad++;
            $display("FAIL xcheck fu=195: model gives %0d",
                     calc(o_au, o_bu, o_cu));
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start(9'd200);
        wait_done(5000, cyc);
        n_cmp++;
        if (cyc !== 4096) begin
            n_bad++;
            $display("FAIL latency fu=200: got %0d want 4096", cyc);
        end
        n_cmp++;
        if ({o_found, o_au, o_bu, o_cu, o_busy} !== 14'd0) begin
            n_bad++;
            $display("FAIL notfound: got f=%b %h busy=%b want 0 000 0",
                     o_found, {o_au, o_bu, o_cu}, o_busy);
        end
        start(9'd0);
        wait_done(10, cyc);
        n_cmp++;
        if (cyc !== 1) begin
            n_bad++;
            $display("FAIL b2b latency: got %0d want 1", cyc);
        end
        n_cmp++;
        if ({o_found, o_au, o_bu, o_cu} !== 13'h1000) begin
            n_bad++;
            $display("FAIL b2b result: got f=%b %h want 1 000",
                     o_found, {o_au, o_bu, o_cu});
        end
    endtask

    task automatic test_reset_mid_search();
        int cyc;
        int seen;
        start(9'd195);
        repeat (99) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        n_cmp++;
        if ({o_busy, o_done, o_found, o_au, o_bu, o_cu} !== 15'd0) begin
            n_bad++;
            $display("FAIL midreset: got %b want 0",
                     {o_busy, o_done, o_found, o_au, o_bu, o_cu});
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        seen = 0;
        repeat (4000) begin
            @(posedge i_clk);
            #1;
            if (o_done || o_busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL noresume: got %0d active cycles want 0", seen);
        end
        start(9'd6);
        wait_done(10, cyc);
        n_cmp++;
        if (cyc !== 2 || {o_found, o_au, o_bu, o_cu} !== 13'h1001) begin
            n_bad++;
            $display("FAIL after reset: cyc=%0d f=%b %h want 2 1 001",
                     cyc, o_found, {o_au, o_bu, o_cu});
        end
    endtask

    initial begin
        test_reset();
        test_match_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_search();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
